// File: rtl/uart_rx_word_fifo.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_word_fifo
// Byte FIFO fed by a level-strobed UART receiver, drained as packed words.
// Rev    : 1.0  initial release
// ============================================================================
module uart_rx_word_fifo #(
  parameter int DEPTH      = 1024,
  parameter int WORD_BYTES = 4,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  input  logic                      rd_req,
  output logic                      rd_valid,
  output logic [8*WORD_BYTES-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty,
  output logic                      full,
  output logic                      overflow,
  input  logic                      ovf_clr
);

  localparam int              AW       = $clog2(DEPTH);
  localparam int              WW       = 8 * WORD_BYTES;
  localparam logic [1:0]      LAST_IDX = 2'(WORD_BYTES - 1);
  localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]     CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            r_rx_prev;
  logic            r_overflow;
  logic            r_rd_valid;
  logic [1:0]      r_byte_idx;
  logic [WW-1:0]   r_acc;
  logic [WW-1:0]   r_rd_data;

  logic            w_capture;
  logic            w_push;
  logic            w_drop;
  logic            w_pop;
  logic            w_last;
  logic [1:0]      w_lane;
  logic [7:0]      w_pop_byte;
  logic [WW-1:0]   w_word;

  assign empty    = (r_count == '0);
  assign full     = (r_count == FULL_CNT);
  assign count    = r_count;
  assign overflow = r_overflow;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;

  // A byte is taken once per strobe: only the low-to-high transition counts.
  assign w_capture  = rx_valid & ~r_rx_prev;
  assign w_push     = w_capture & ~full;
  assign w_drop     = w_capture & full;
  assign w_pop      = (r_state == COLLECT) & ~empty;
  assign w_last     = w_pop & (r_byte_idx == LAST_IDX);
  assign w_pop_byte = r_mem[r_rd_ptr];
  assign w_lane     = BIG_ENDIAN ? (LAST_IDX - r_byte_idx) : r_byte_idx;

  always_comb begin
    w_word = r_acc;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (w_lane == 2'(i)) begin
        w_word[i*8 +: 8] = w_pop_byte;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (rd_req) w_state_nxt = COLLECT;
      COLLECT: if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn && w_push) begin
      r_mem[r_wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rx_prev  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_rx_prev <= rx_valid;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      // A drop in the same cycle as a clear leaves the flag set.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_byte_idx <= '0;
      r_acc      <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_last;
      if (r_state == IDLE && rd_req) begin
        r_byte_idx <= '0;
      end else if (w_pop) begin
        r_byte_idx <= r_byte_idx + 2'd1;
      end
      if (w_pop)  r_acc     <= w_word;
      if (w_last) r_rd_data <= w_word;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_word_fifo.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_rx_word_fifo
// Two configurations driven in parallel and compared against a queue model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_rx_word_fifo;

  localparam int DA = 4;
  localparam int WA = 4;
  localparam int DB = 8;
  localparam int WB = 2;
  localparam int M_IDLE    = 0;
  localparam int M_COLLECT = 1;
  localparam int M_DONE    = 2;

  logic        clk      = 1'b0;
  logic        rstn     = 1'b0;
  logic        rx_valid = 1'b0;
  logic        rd_req   = 1'b0;
  logic        ovf_clr  = 1'b0;
  logic [7:0]  rx_data  = 8'h00;

  logic        va, vb, ea, eb, fa, fb, oa, ob;
  logic [31:0] da;
  logic [15:0] db;
  logic [2:0]  ca;
  logic [3:0]  cb;

  always #5 clk = ~clk;

  uart_rx_word_fifo #(.DEPTH(DA), .WORD_BYTES(WA), .BIG_ENDIAN(1'b0)) dut_a (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
    .rd_req(rd_req), .rd_valid(va), .rd_data(da), .count(ca),
    .empty(ea), .full(fa), .overflow(oa), .ovf_clr(ovf_clr)
  );

  uart_rx_word_fifo #(.DEPTH(DB), .WORD_BYTES(WB), .BIG_ENDIAN(1'b1)) dut_b (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
    .rd_req(rd_req), .rd_valid(vb), .rd_data(db), .count(cb),
    .empty(eb), .full(fb), .overflow(ob), .ovf_clr(ovf_clr)
  );

  // Reference model: byte queue per configuration plus the collected word.
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  int          mst   [2];
  int          mncol [2];
  logic [7:0]  mcol  [2][4];
  logic [31:0] mdata [2];
  logic        movf  [2];
  logic        mprev [2];

  int errors = 0;
  int checks = 0;
  int cnt_va = 0;
  int cnt_vb = 0;
  logic [31:0] cap_da = '0;
  logic [15:0] cap_db = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_step(input int d);
    logic [7:0]  cur[$];
    int          depth, wb, pre, lane;
    logic        cap;
    logic [31:0] word;
    depth = (d == 0) ? DA : DB;
    wb    = (d == 0) ? WA : WB;
    if (!rstn) begin
      if (d == 0) q0.delete(); else q1.delete();
      mst[d] = M_IDLE; mncol[d] = 0; mdata[d] = '0; movf[d] = 1'b0; mprev[d] = 1'b0;
      return;
    end
    if (d == 0) cur = q0; else cur = q1;
    pre      = cur.size();
    cap      = rx_valid && !mprev[d];
    mprev[d] = rx_valid;
    case (mst[d])
      M_IDLE: if (rd_req) begin mst[d] = M_COLLECT; mncol[d] = 0; end
      M_COLLECT: if (pre > 0) begin
        mcol[d][mncol[d]] = cur.pop_front();
        mncol[d]++;
        if (mncol[d] == wb) begin
          word = '0;
          for (int i = 0; i < wb; i++) begin
            lane = (d == 1) ? (wb - 1 - i) : i;
            word[lane*8 +: 8] = mcol[d][i];
          end
          mdata[d] = word;
          mst[d]   = M_DONE;
        end
      end
      default: mst[d] = M_IDLE;
    endcase
    if (cap && pre == depth) begin
      movf[d] = 1'b1;
    end else begin
      if (cap) cur.push_back(rx_data);
      if (ovf_clr) movf[d] = 1'b0;
    end
    if (d == 0) q0 = cur; else q1 = cur;
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  always @(negedge clk) begin
    chk("a.count",    32'(ca), 32'(q0.size()));
    chk("a.empty",    32'(ea), 32'(q0.size() == 0));
    chk("a.full",     32'(fa), 32'(q0.size() == DA));
    chk("a.overflow", 32'(oa), 32'(movf[0]));
    chk("a.rd_valid", 32'(va), 32'(mst[0] == M_DONE));
    chk("a.rd_data",  da,      mdata[0]);
    chk("b.count",    32'(cb), 32'(q1.size()));
    chk("b.empty",    32'(eb), 32'(q1.size() == 0));
    chk("b.full",     32'(fb), 32'(q1.size() == DB));
    chk("b.overflow", 32'(ob), 32'(movf[1]));
    chk("b.rd_valid", 32'(vb), 32'(mst[1] == M_DONE));
    chk("b.rd_data",  32'(db), mdata[1]);
    if (va) begin cnt_va++; cap_da = da; end
    if (vb) begin cnt_vb++; cap_db = db; end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    cyc(); cyc();
    rx_valid = 1'b0;
    cyc();
  endtask

  task automatic do_reset();
    rd_req = 1'b0; rx_valid = 1'b0; ovf_clr = 1'b0;
    rstn = 1'b0;
    cyc(); cyc();
    rstn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          na, nb, base;
    logic [31:0] expw;
    logic [7:0]  b;

    // Reset while rx_valid is already high, then hold the level strobe.
    rx_valid = 1'b1; rx_data = 8'h5A;
    rstn = 1'b0;
    repeat (3) cyc();
    chk("rst.a.empty", 32'(ea), 32'd1);
    chk("rst.a.full",  32'(fa), 32'd0);
    chk("rst.a.count", 32'(ca), 32'd0);
    chk("rst.b.count", 32'(cb), 32'd0);
    chk("rst.a.ovf",   32'(oa), 32'd0);
    rstn = 1'b1;
    repeat (50) cyc();
    chk("level.a.count", 32'(ca), 32'd1);
    chk("level.b.count", 32'(cb), 32'd1);
    chk("level.model",   32'(q0.size()), 32'd1);
    do_reset();

    // Little-endian word on A, big-endian half-words on B, with latency.
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    chk("le.a.full",  32'(fa), 32'd1);
    chk("le.b.count", 32'(cb), 32'd4);
    rd_req = 1'b1; cyc(); rd_req = 1'b0;
    na = 0; nb = 0;
    for (int n = 1; n <= 20; n++) begin
      if (va && na == 0) begin
        na = n;
        chk("le.a.data",  da, 32'h44332211);
        chk("le.a.model", mdata[0], 32'h44332211);
        chk("le.a.count", 32'(ca), 32'd0);
      end
      if (vb && nb == 0) begin
        nb = n;
        chk("be.b.data",  32'(db), 32'h1122);
        chk("be.b.model", mdata[1], 32'h1122);
        chk("be.b.count", 32'(cb), 32'd2);
      end
      cyc();
    end
    chk("le.a.latency", 32'(na), 32'd5);
    chk("be.b.latency", 32'(nb), 32'd3);
    base = cnt_vb;
    rd_req = 1'b1; cyc(); rd_req = 1'b0;
    repeat (6) cyc();
    chk("be.b.words", 32'(cnt_vb - base), 32'd1);
    chk("be.b.data2", 32'(cap_db), 32'h3344);

    // Overflow on A: fifth byte lost, flag sticky until cleared.
    do_reset();
    base = cnt_va;
    for (int k = 1; k <= 5; k++) send(8'hA0 + 8'(k));
    chk("ovf.a.full",  32'(fa), 32'd1);
    chk("ovf.a.flag",  32'(oa), 32'd1);
    chk("ovf.a.count", 32'(ca), 32'd4);
    chk("ovf.b.flag",  32'(ob), 32'd0);
    chk("ovf.model",   32'(movf[0]), 32'd1);
    rd_req = 1'b1; cyc(); rd_req = 1'b0;
    repeat (8) cyc();
    chk("ovf.a.words",  32'(cnt_va - base), 32'd1);
    chk("ovf.a.data",   cap_da, 32'hA4A3A2A1);
    chk("ovf.a.sticky", 32'(oa), 32'd1);
    ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
    chk("ovf.a.clr", 32'(oa), 32'd0);

    // Starve, then trickle bytes across pointer wrap for three words.
    do_reset();
    base = cnt_va;
    rd_req = 1'b1; cyc(); rd_req = 1'b0;
    repeat (15) cyc();
    chk("starve.a.words", 32'(cnt_va - base), 32'd0);
    chk("starve.a.count", 32'(ca), 32'd0);
    for (int w = 0; w < 3; w++) begin
      if (w > 0) begin rd_req = 1'b1; cyc(); rd_req = 1'b0; end
      expw = '0;
      for (int k = 0; k < 4; k++) begin
        b = 8'h10 * 8'(w + 1) + 8'(k);
        expw[k*8 +: 8] = b;
        send(b);
        repeat (3) cyc();
      end
      repeat (4) cyc();
      chk("wrap.a.words", 32'(cnt_va - base), 32'(w + 1));
      chk("wrap.a.data",  cap_da, expw);
    end

    // Reset in the middle of a collection after two pops.
    do_reset();
    send(8'hC1); send(8'hC2);
    base = cnt_va;
    rd_req = 1'b1; cyc(); rd_req = 1'b0;
    repeat (4) cyc();
    chk("midrst.a.popped", 32'(ca), 32'd0);
    rstn = 1'b0; cyc(); rstn = 1'b1;
    repeat (10) cyc();
    chk("midrst.a.nopulse", 32'(cnt_va - base), 32'd0);
    chk("midrst.a.count",   32'(ca), 32'd0);
    send(8'hC3); send(8'hC4);
    chk("midrst.a.idle", 32'(ca), 32'd2);

    // Randomized traffic, checked every cycle against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) rx_valid = ~rx_valid;
      rx_data = 8'($urandom);
      rd_req  = ($urandom_range(0, 3) == 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
      rstn    = ($urandom_range(0, 399) != 0);
      cyc();
    end
    rstn = 1'b1; rd_req = 1'b0; rx_valid = 1'b0; ovf_clr = 1'b0;
    repeat (10) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
